// File: rtl/reg8_write_arbiter.sv
// reg8_write_arbiter: round-robin arbiter that writes a shared register, verifies readback and retries.
module reg8_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         rdata,
    output logic                     busy,
    output logic [WIDTH-1:0]         reg_d,
    input  logic [WIDTH-1:0]         reg_q
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;
    state_t             state, state_n;
    logic [PW-1:0]      ptr, ptr_n, sel, sel_n, pick, k;
    logic [WIDTH-1:0]   data, data_n, rdata_n, reg_d_n;
    logic [RW-1:0]      retry, retry_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic               done_n, err_n, hit;
    logic [WIDTH-1:0]   slot [NUM_REQ];
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) slot[i] = wdata[i*WIDTH +: WIDTH];
    end
    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        pick = ptr;
        hit  = 1'b0;
        k    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % NUM_REQ);
            if (req[k]) begin
                pick = k;
                hit  = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        data_n  = data;
        retry_n = retry;
        gnt_n   = gnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rdata_n = rdata;
        reg_d_n = reg_d;
        case (state)
            IDLE: if (hit) begin
                sel_n   = pick;
                data_n  = slot[pick];
                reg_d_n = slot[pick];
                gnt_n   = NUM_REQ'(1) << pick;
                state_n = DRIVE;
            end
            DRIVE: state_n = CHECK;
            CHECK: if (reg_q == data || int'(retry) == MAX_RETRY) begin
                state_n = RESP;
                done_n  = 1'b1;
                err_n   = reg_q != data;
                rdata_n = reg_q;
            end else begin
                retry_n = retry + 1'b1;
                reg_d_n = data;
                state_n = DRIVE;
            end
            RESP: begin
                state_n = IDLE;
                gnt_n   = '0;
                retry_n = '0;
                ptr_n   = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            data  <= '0;
            retry <= '0;
            gnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            busy  <= 1'b0;
            reg_d <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            data  <= data_n;
            retry <= retry_n;
            gnt   <= gnt_n;
            done  <= done_n;
            err   <= err_n;
            rdata <= rdata_n;
            busy  <= state_n != IDLE;
            reg_d <= reg_d_n;
        end
    end
endmodule

// File: tb/tb_reg8_write_arbiter.sv
// tb_reg8_write_arbiter: randomized transaction-level check of the register write arbiter.
module tb_reg8_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = $clog2(N);
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic           done, err, busy;
    logic [W-1:0]   rdata, reg_d, reg_q, q_reg;
    logic [W-1:0]   force_val = '0;
    logic           force_en = 1'b0;
    logic [W-1:0]   wd [N];
    int checks = 0, passed = 0, mptr = 0;

    always #5 clk = ~clk;
    // The shared register recirculates whatever is on D every cycle.
    always @(posedge clk) q_reg <= reg_d;
    assign reg_q = force_en ? force_val : q_reg;

    reg8_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_RETRY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .busy(busy), .reg_d(reg_d), .reg_q(reg_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [W-1:0] v);
        wd[i] = v;
        wdata[i*W +: W] = v;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) if (r[PW'((p + j) % N)]) return (p + j) % N;
        return -1;
    endfunction

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        to = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done) begin
                lat = c;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        force_en = 1'b0;
        repeat (2) tick();
        checks++; if ({gnt, done, err, busy} !== '0) $display("FAIL reset_ctl: got gnt=%b done=%b err=%b busy=%b want 0", gnt, done, err, busy); else passed++;
        checks++; if (rdata !== '0) $display("FAIL reset_rdata: got %h want 00", rdata); else passed++;
        checks++; if (reg_d !== '0) $display("FAIL reset_reg_d: got %h want 00", reg_d); else passed++;
        rst_n = 1'b1;
        mptr = 0;
        tick();
    endtask

    task automatic test_single();
        set_wd(1, 8'hA5);
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010 || busy !== 1'b1) $display("FAIL single_gnt: got gnt=%b busy=%b want 0010/1", gnt, busy); else passed++;
        tick();
        checks++; if (reg_q !== 8'hA5 || done !== 1'b0) $display("FAIL single_q: got q=%h done=%b want a5/0", reg_q, done); else passed++;
        tick();
        checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 8'hA5) $display("FAIL single_done: got done=%b err=%b rdata=%h want 1/0/a5", done, err, rdata); else passed++;
        req = '0;
        tick();
        checks++; if (gnt !== '0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL single_idle: got gnt=%b busy=%b done=%b want 0", gnt, busy, done); else passed++;
        mptr = 2;
    endtask

    task automatic test_round_robin();
        int lat, exp;
        bit to;
        test_reset();
        for (int i = 0; i < N; i++) set_wd(i, W'($urandom));
        req = '1;
        for (int t = 0; t < 5; t++) begin
            exp = pick(req, mptr);
            wait_done(lat, to);
            checks++; if (to || lat != (t == 0 ? 3 : 4)) $display("FAIL rr_latency: got %0d (timeout=%0d) want %0d", lat, to, t == 0 ? 3 : 4); else passed++;
            checks++; if (gnt !== N'(1) << exp) $display("FAIL rr_gnt: got %b want %b", gnt, N'(1) << exp); else passed++;
            checks++; if (rdata !== wd[exp] || err !== 1'b0) $display("FAIL rr_data: got %h err=%b want %h err=0", rdata, err, wd[exp]); else passed++;
            mptr = (exp + 1) % N;
            set_wd(exp, W'($urandom));
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int lat, exp;
        bit to;
        repeat (25) begin
            for (int i = 0; i < N; i++) set_wd(i, W'($urandom));
            req = N'($urandom_range(1, (1 << N) - 1));
            exp = pick(req, mptr);
            wait_done(lat, to);
            checks++; if (to || lat != 3) $display("FAIL rand_latency: got %0d (timeout=%0d) want 3", lat, to); else passed++;
            checks++; if (gnt !== N'(1) << exp) $display("FAIL rand_gnt: got %b want %b req=%b", gnt, N'(1) << exp, req); else passed++;
            checks++; if (rdata !== wd[exp] || err !== 1'b0) $display("FAIL rand_data: got %h err=%b want %h err=0", rdata, err, wd[exp]); else passed++;
            req = '0;
            mptr = (exp + 1) % N;
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic test_fault_retry();
        int lat;
        bit to;
        set_wd(0, 8'h3C);
        force_val = 8'h00;
        force_en = 1'b1;
        req = 4'b0001;
        repeat (3) tick();
        checks++; if (done !== 1'b0 || gnt !== 4'b0001) $display("FAIL retry_mid: got done=%b gnt=%b want 0/0001", done, gnt); else passed++;
        force_en = 1'b0;
        wait_done(lat, to);
        checks++; if (to || lat + 3 != 5) $display("FAIL retry_latency: got %0d want 5", lat + 3); else passed++;
        checks++; if (err !== 1'b0 || rdata !== 8'h3C) $display("FAIL retry_data: got err=%b rdata=%h want 0/3c", err, rdata); else passed++;
        req = '0;
        mptr = 1;
        tick();
    endtask

    task automatic test_fault_err();
        int lat;
        bit to;
        set_wd(1, 8'h0F);
        force_val = 8'hFF;
        force_en = 1'b1;
        req = 4'b0010;
        wait_done(lat, to);
        checks++; if (to || lat != 7) $display("FAIL err_latency: got %0d want 7", lat); else passed++;
        checks++; if (err !== 1'b1 || rdata !== 8'hFF || gnt !== 4'b0010) $display("FAIL err_resp: got err=%b rdata=%h gnt=%b want 1/ff/0010", err, rdata, gnt); else passed++;
        req = '0;
        force_en = 1'b0;
        mptr = 2;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || reg_d !== 8'h0F) $display("FAIL err_after: got busy=%b reg_d=%h want 0/0f", busy, reg_d); else passed++;
        set_wd(2, W'($urandom));
        req = 4'b0100;
        wait_done(lat, to);
        checks++; if (to || lat != 3 || err !== 1'b0 || rdata !== wd[2]) $display("FAIL err_recover: got lat=%0d err=%b rdata=%h want 3/0/%h", lat, err, rdata, wd[2]); else passed++;
        req = '0;
        mptr = 3;
        tick();
    endtask

    task automatic test_drop_req();
        logic [W-1:0] d0;
        d0 = W'($urandom);
        set_wd(2, d0);
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) $display("FAIL drop_gnt: got %b want 0100", gnt); else passed++;
        req = '0;
        set_wd(2, ~d0);
        repeat (2) tick();
        checks++; if (done !== 1'b1 || gnt !== 4'b0100 || rdata !== d0 || err !== 1'b0) $display("FAIL drop_done: got done=%b gnt=%b rdata=%h want 1/0100/%h", done, gnt, rdata, d0); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL drop_idle: got busy=%b want 0", busy); else passed++;
        mptr = 3;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        set_wd(1, W'($urandom));
        req = 4'b0010;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({gnt, done, err, busy} !== '0 || rdata !== '0 || reg_d !== '0) $display("FAIL rstmid_out: got gnt=%b done=%b busy=%b rdata=%h reg_d=%h want 0", gnt, done, busy, rdata, reg_d); else passed++;
        req = '0;
        repeat (2) begin
            tick();
            checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else passed++;
        end
        rst_n = 1'b1;
        mptr = 0;
        set_wd(3, W'($urandom));
        req = 4'b1000;
        wait_done(lat, to);
        checks++; if (to || lat != 3 || gnt !== N'(1) << pick(4'b1000, mptr)) $display("FAIL rstmid_serve: got lat=%0d gnt=%b want 3/1000", lat, gnt); else passed++;
        checks++; if (rdata !== wd[3] || err !== 1'b0) $display("FAIL rstmid_data: got %h err=%b want %h", rdata, err, wd[3]); else passed++;
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_fault_retry();
        test_fault_err();
        test_drop_req();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
